mips_cpu_harvard: RTL and testbench
===================================

MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000: PC value loaded by reset.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- active  out  1  high while executing; low once halted.
- register_v0  out  32  live value of GPR $2.
- clk_enable  in  1  high = state may update this edge.
- instr_address  out  32  byte address of current instruction, equal to PC.
- instr_readdata  in  32  instruction word, combinational from instr_address.
- data_address  out  32  byte address for load/store.
- data_write  out  1  store strobe.
- data_read  out  1  load strobe.
- data_writedata  out  32  store data.
- data_readdata  in  32  load data, combinational in the same cycle.

Function
REQ-003 SHALL be single-cycle: one instruction retires per enabled rising edge; no pipeline stalls.
REQ-004 SHALL hold state PC, nPC and 32x32 GPRs; $0 reads 0 and writes to it are discarded.
REQ-005 SHALL implement the MIPS branch delay slot: after a taken branch or jump, the next sequential instruction executes before the target.
- PC <= nPC.
- nPC <= target if taken, else nPC+4.
REQ-006 SHALL support these R-type instructions (opcode 0): ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
REQ-007 SHALL support these I-type and J-type instructions: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-008 SHALL apply these immediate and address rules:
- Immediates sign-extended for ADDIU, SLTI, SLTIU, LW, SW and branches; zero-extended for ANDI, ORI, XORI.
- Branch target = PC+4 + (sext(imm)<<2).
- J/JAL target = {(PC+4)[31:28], idx, 2'b00}.
REQ-009 SHALL write PC+8 as the link value: to $31 for JAL, to rd for JALR.
REQ-010 SHALL perform all arithmetic mod 2^32 with no overflow traps.
REQ-011 SHALL treat unrecognised encodings as NOP.
REQ-012 SHALL drive the load/store interface combinationally:
- LW: data_read=1, data_address=rs+sext(imm); rt <= data_readdata at the edge.
- SW: data_write=1, data_writedata=rt.
- Otherwise both strobes are 0.
REQ-013 SHALL halt when PC==0:
- active=0 combinationally.
- No GPR write, memory strobe or PC change while halted.
- instr_address stays 0.
REQ-014 SHALL freeze all state while clk_enable=0, outputs unchanged except combinational decode of the held PC; strobes are forced 0.
REQ-015 SHALL, when a branch sits in a delay slot, use the later branch's target per the PC/nPC rule of REQ-005.

Reset
REQ-016 SHALL on reset=1, asynchronously and independent of clk_enable:
- PC=RESET_VECTOR, nPC=RESET_VECTOR+4.
- All GPRs=0, active=1, register_v0=0.
REQ-017 SHALL come up in the reset state at time zero even if reset is never asserted.
REQ-018 SHALL discard in-flight state when reset asserts mid-run; execution restarts at RESET_VECTOR on the first enabled edge after release.

Structure
REQ-019 SHALL keep opcode/funct constants and RESET_VECTOR default in a shared package mips_pkg.
REQ-020 SHALL contain one sub-module mips_alu (32-bit ops, shift amount input, SLT/SLTU compare).
REQ-021 SHALL pair with companion module mips_cpu_data_memory (clk, clk_enable, address, writedata, write, read, reset, readdata), which has:
- combinational read;
- write on enabled rising edge;
- word-aligned addressing.

Verification
REQ-022 Bench SHALL cover: ADDIU $1,$1,1; BNE $0,$1,+2; ADDIU $2,$2,1 (delay slot); skipped ADDIU $2; ADDIU $2,$2,1; JR $0; ADDIU $0,$0,0 -> at PC==0, register_v0==2 and active==0.
REQ-023 Bench SHALL cover: BEQ $0,$1 with $1=1, not taken -> both following ADDIU $2 execute, v0==2 at halt.
REQ-024 Bench SHALL cover: LUI/ORI $3=0x12345678; SW $3,4($0); LW $2,4($0); JR $0 -> v0==0x12345678.
REQ-025 Bench SHALL cover: JAL from 0xBFC00000 -> $31==0xBFC00008; returning JR $31 resumes at 0xBFC00008.
REQ-026 Bench SHALL cover: clk_enable=0 for 5 edges mid-program -> PC and v0 unchanged, strobes 0; resume gives the same final v0.
REQ-027 Bench SHALL cover: reset pulse mid-program -> instr_address==0xBFC00000 immediately, v0==0, program reruns to the same result.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct encodings, ALU operation set and the
// default reset vector for the Harvard MIPS core.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational 32-bit ALU.
//   op    - operation select (alu_op_t)
//   a, b  - operands; shifts act on b
//   shamt - shift amount
//   y     - result (compares return 0/1)
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'b0, a < b};
            ALU_SLL:   y = b << shamt;
            ALU_SRL:   y = b >> shamt;
            ALU_SRA:   y = $unsigned($signed(b) >>> shamt);
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_data_memory.sv
// mips_cpu_data_memory: word-addressed data RAM paired with the core.
//   address/writedata/write/read - core load/store interface
//   readdata - combinational, 0 unless read is high
//   Writes land on an enabled rising edge; reset clears contents.
module mips_cpu_data_memory (
    input  logic        clk,
    input  logic        clk_enable,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    input  logic        reset,
    output logic [31:0] readdata
);

    logic [31:0] mem [64];
    logic [5:0]  idx;

    // Byte address -> word index; low two bits ignored.
    assign idx      = address[7:2];
    assign readdata = read ? mem[idx] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (clk_enable && write) begin
            mem[idx] <= writedata;
        end
    end

endmodule

// File: rtl/mips_cpu_harvard.sv
// mips_cpu_harvard: single-cycle MIPS-I subset core, Harvard interface,
// with branch delay slots.
//   clk/reset/clk_enable - clock, async active-high reset, edge enable
//   active               - low once PC reaches 0 (halted)
//   register_v0          - live $2
//   instr_address/instr_readdata - instruction fetch (comb. read)
//   data_*               - load/store port (comb. read, strobes gated)
module mips_cpu_harvard
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [31:0] NPC_RESET = RESET_VECTOR + 32'd4;

    // PC/nPC are stored XORed with their reset values so all-zero power-up
    // contents already are the reset state; the GPR file is zero at reset.
    logic [31:0] pc_x, npc_x;
    logic [31:0] pc, npc;
    logic [31:0] regs [32];

    assign pc  = pc_x  ^ RESET_VECTOR;
    assign npc = npc_x ^ NPC_RESET;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, sext_imm, pc4;

    assign op       = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign sa       = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign imm      = instr_readdata[15:0];
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign sext_imm = sext16(imm);
    assign pc4      = pc + 32'd4;

    logic    halted, en;
    assign halted = (pc == 32'h0);
    assign en     = clk_enable && !halted;

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_y, target, wr_data;
    logic [4:0]  alu_sa, wr_addr;
    logic        wr_en, link, is_lw, is_sw, taken;

    mips_alu u_alu (.op(alu_op), .a(rs_val), .b(alu_b), .shamt(alu_sa), .y(alu_y));

    always_comb begin
        alu_op  = ALU_ADD;
        alu_b   = rt_val;
        alu_sa  = sa;
        wr_en   = 1'b0;
        wr_addr = rd;
        link    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        taken   = 1'b0;
        target  = pc4 + (sext_imm << 2);
        case (op)
            OP_SPECIAL: begin
                wr_en = 1'b1;
                case (funct)
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_SLLV: begin alu_op = ALU_SLL; alu_sa = rs_val[4:0]; end
                    F_SRLV: begin alu_op = ALU_SRL; alu_sa = rs_val[4:0]; end
                    F_SRAV: begin alu_op = ALU_SRA; alu_sa = rs_val[4:0]; end
                    F_ADDU: alu_op = ALU_ADD;
                    F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_JR:   begin wr_en = 1'b0; taken = 1'b1; target = rs_val; end
                    F_JALR: begin link = 1'b1; taken = 1'b1; target = rs_val; end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_J:     begin taken = 1'b1; target = {pc4[31:28], instr_readdata[25:0], 2'b00}; end
            OP_JAL:   begin
                taken   = 1'b1;
                target  = {pc4[31:28], instr_readdata[25:0], 2'b00};
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                link    = 1'b1;
            end
            OP_BEQ:   taken = (rs_val == rt_val);
            OP_BNE:   taken = (rs_val != rt_val);
            OP_ADDIU: begin alu_op = ALU_ADD;   alu_b = sext_imm;         wr_en = 1'b1; wr_addr = rt; end
            OP_SLTI:  begin alu_op = ALU_SLT;   alu_b = sext_imm;         wr_en = 1'b1; wr_addr = rt; end
            OP_SLTIU: begin alu_op = ALU_SLTU;  alu_b = sext_imm;         wr_en = 1'b1; wr_addr = rt; end
            OP_ANDI:  begin alu_op = ALU_AND;   alu_b = {16'h0, imm};     wr_en = 1'b1; wr_addr = rt; end
            OP_ORI:   begin alu_op = ALU_OR;    alu_b = {16'h0, imm};     wr_en = 1'b1; wr_addr = rt; end
            OP_XORI:  begin alu_op = ALU_XOR;   alu_b = {16'h0, imm};     wr_en = 1'b1; wr_addr = rt; end
            OP_LUI:   begin alu_op = ALU_PASSB; alu_b = {imm, 16'h0};     wr_en = 1'b1; wr_addr = rt; end
            OP_LW:    begin alu_b = sext_imm; is_lw = 1'b1;               wr_en = 1'b1; wr_addr = rt; end
            OP_SW:    begin alu_b = sext_imm; is_sw = 1'b1; end
            default:  ;
        endcase
    end

    assign wr_data = is_lw ? data_readdata : (link ? pc + 32'd8 : alu_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_x  <= '0;
            npc_x <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (en) begin
            pc_x  <= npc ^ RESET_VECTOR;
            npc_x <= (taken ? target : npc + 32'd4) ^ NPC_RESET;
            if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
        end
    end

    assign active         = !halted;
    assign register_v0    = regs[2];
    assign instr_address  = pc;
    assign data_address   = alu_y;
    assign data_writedata = rt_val;
    assign data_read      = en && is_lw;
    assign data_write     = en && is_sw;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
module tb_mips_cpu_harvard;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
    logic        active, data_write, data_read;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic [31:0] imem [64];

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign instr_readdata = (instr_address[31:8] == RV[31:8]) ? imem[instr_address[7:2]] : 32'h0;

    mips_cpu_harvard #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    mips_cpu_data_memory u_dmem (
        .clk(clk), .clk_enable(clk_enable), .address(data_address),
        .writedata(data_writedata), .write(data_write), .read(data_read),
        .reset(reset), .readdata(data_readdata)
    );

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [31:0] JR_0   = 32'h00000008;
    localparam logic [31:0] JR_31  = 32'h03E00008;

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (active === 1'b1 && n < 200) begin step(1); n++; end
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL %s halt_timeout active=%b pc=%h", name, active, instr_address);
        end
    endtask

    // BNE program: taken branch with delay slot, then JR $0.
    task automatic load_bne_prog;
        clear_imem();
        imem[0] = itype(6'h09, 5'd1, 5'd1, 16'd1);
        imem[1] = itype(6'h05, 5'd0, 5'd1, 16'd2);
        imem[2] = itype(6'h09, 5'd2, 5'd2, 16'd1);
        imem[3] = itype(6'h09, 5'd2, 5'd2, 16'd1);
        imem[4] = itype(6'h09, 5'd2, 5'd2, 16'd1);
        imem[5] = JR_0;
        imem[6] = itype(6'h09, 5'd0, 5'd0, 16'd0);
    endtask

    task automatic load_ls_prog;
        clear_imem();
        imem[0] = itype(6'h0F, 5'd0, 5'd3, 16'h1234);
        imem[1] = itype(6'h0D, 5'd3, 5'd3, 16'h5678);
        imem[2] = itype(6'h2B, 5'd0, 5'd3, 16'd4);
        imem[3] = itype(6'h23, 5'd0, 5'd2, 16'd4);
        imem[4] = JR_0;
        imem[5] = NOP;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (instr_address !== RV) begin failures++; $display("FAIL t0_pc got=%h exp=%h", instr_address, RV); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL t0_active got=%b exp=1", active); end
        checks++; if (register_v0 !== 32'h0) begin failures++; $display("FAIL t0_v0 got=%h exp=0", register_v0); end
        do_reset();
        checks++; if (instr_address !== RV) begin failures++; $display("FAIL rst_pc got=%h exp=%h", instr_address, RV); end
        checks++; if ({data_read, data_write} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {data_read, data_write}); end
    endtask

    task automatic test_branch_taken;
        load_bne_prog();
        do_reset();
        run_to_halt("bne");
        checks++; if (register_v0 !== 32'd2) begin failures++; $display("FAIL bne_v0 got=%h exp=2", register_v0); end
        checks++; if (instr_address !== 32'h0) begin failures++; $display("FAIL bne_pc got=%h exp=0", instr_address); end
        step(3);
        checks++; if (instr_address !== 32'h0 || active !== 1'b0) begin failures++; $display("FAIL halt_hold pc=%h active=%b exp pc=0 active=0", instr_address, active); end
        checks++; if (register_v0 !== 32'd2) begin failures++; $display("FAIL halt_v0 got=%h exp=2", register_v0); end
        checks++; if ({data_read, data_write} !== 2'b00) begin failures++; $display("FAIL halt_strobes got=%b exp=00", {data_read, data_write}); end
    endtask

    task automatic test_branch_not_taken;
        clear_imem();
        imem[0] = itype(6'h09, 5'd1, 5'd1, 16'd1);
        imem[1] = itype(6'h04, 5'd0, 5'd1, 16'd2);
        imem[2] = itype(6'h09, 5'd2, 5'd2, 16'd1);
        imem[3] = itype(6'h09, 5'd2, 5'd2, 16'd1);
        imem[4] = JR_0;
        imem[5] = NOP;
        do_reset();
        run_to_halt("beq");
        checks++; if (register_v0 !== 32'd2) begin failures++; $display("FAIL beq_v0 got=%h exp=2", register_v0); end
    endtask

    task automatic test_load_store;
        load_ls_prog();
        do_reset();
        step(2);
        checks++; if (data_write !== 1'b1 || data_read !== 1'b0) begin failures++; $display("FAIL sw_strobes got=%b%b exp=10", data_write, data_read); end
        checks++; if (data_address !== 32'd4) begin failures++; $display("FAIL sw_addr got=%h exp=4", data_address); end
        checks++; if (data_writedata !== 32'h12345678) begin failures++; $display("FAIL sw_data got=%h exp=12345678", data_writedata); end
        step(1);
        checks++; if (data_read !== 1'b1 || data_write !== 1'b0) begin failures++; $display("FAIL lw_strobes got=%b%b exp=01", data_read, data_write); end
        checks++; if (data_address !== 32'd4) begin failures++; $display("FAIL lw_addr got=%h exp=4", data_address); end
        run_to_halt("ls");
        checks++; if (register_v0 !== 32'h12345678) begin failures++; $display("FAIL ls_v0 got=%h exp=12345678", register_v0); end
    endtask

    task automatic test_jal;
        clear_imem();
        imem[0]  = {6'h03, 26'h3F00008};               // JAL 0xBFC00020
        imem[1]  = NOP;
        imem[2]  = itype(6'h09, 5'd2, 5'd2, 16'd5);
        imem[3]  = JR_0;
        imem[4]  = NOP;
        imem[8]  = rtype(5'd31, 5'd0, 5'd2, 5'd0, 6'h21); // ADDU $2,$31,$0
        imem[9]  = JR_31;
        imem[10] = NOP;
        do_reset();
        step(2);
        checks++; if (instr_address !== 32'hBFC00020) begin failures++; $display("FAIL jal_target got=%h exp=bfc00020", instr_address); end
        step(1);
        checks++; if (register_v0 !== 32'hBFC00008) begin failures++; $display("FAIL jal_link got=%h exp=bfc00008", register_v0); end
        step(2);
        checks++; if (instr_address !== 32'hBFC00008) begin failures++; $display("FAIL jr31_return got=%h exp=bfc00008", instr_address); end
        run_to_halt("jal");
        checks++; if (register_v0 !== 32'hBFC0000D) begin failures++; $display("FAIL jal_v0 got=%h exp=bfc0000d", register_v0); end
    endtask

    task automatic test_alu;
        logic [31:0] exp_v0 [22];
        clear_imem();
        imem[0]  = itype(6'h09, 5'd0, 5'd2, 16'hFFF8);           exp_v0[0]  = 32'hFFFFFFF8;
        imem[1]  = rtype(5'd0, 5'd2, 5'd2, 5'd1, 6'h03);        exp_v0[1]  = 32'hFFFFFFFC; // SRA
        imem[2]  = rtype(5'd0, 5'd2, 5'd2, 5'd28, 6'h02);       exp_v0[2]  = 32'h0000000F; // SRL
        imem[3]  = rtype(5'd0, 5'd2, 5'd2, 5'd4, 6'h00);        exp_v0[3]  = 32'h000000F0; // SLL
        imem[4]  = itype(6'h0E, 5'd2, 5'd2, 16'hFFFF);           exp_v0[4]  = 32'h0000FF0F; // XORI
        imem[5]  = itype(6'h09, 5'd0, 5'd5, 16'hFFFF);           exp_v0[5]  = 32'h0000FF0F;
        imem[6]  = rtype(5'd2, 5'd5, 5'd2, 5'd0, 6'h2B);        exp_v0[6]  = 32'h1;        // SLTU
        imem[7]  = rtype(5'd5, 5'd2, 5'd2, 5'd0, 6'h2A);        exp_v0[7]  = 32'h1;        // SLT
        imem[8]  = rtype(5'd2, 5'd5, 5'd2, 5'd0, 6'h23);        exp_v0[8]  = 32'h2;        // SUBU
        imem[9]  = rtype(5'd2, 5'd0, 5'd2, 5'd0, 6'h27);        exp_v0[9]  = 32'hFFFFFFFD; // NOR
        imem[10] = itype(6'h0C, 5'd2, 5'd2, 16'h8001);           exp_v0[10] = 32'h00008001; // ANDI
        imem[11] = itype(6'h0A, 5'd2, 5'd2, 16'hFFFF);           exp_v0[11] = 32'h0;        // SLTI
        imem[12] = itype(6'h09, 5'd0, 5'd6, 16'd3);              exp_v0[12] = 32'h0;
        imem[13] = itype(6'h09, 5'd0, 5'd2, 16'h0041);           exp_v0[13] = 32'h41;
        imem[14] = rtype(5'd6, 5'd2, 5'd2, 5'd0, 6'h06);        exp_v0[14] = 32'h8;        // SRLV
        imem[15] = itype(6'h0B, 5'd2, 5'd2, 16'd9);              exp_v0[15] = 32'h1;        // SLTIU
        imem[16] = itype(6'h0F, 5'd0, 5'd2, 16'h8000);           exp_v0[16] = 32'h80000000; // LUI
        imem[17] = rtype(5'd6, 5'd2, 5'd2, 5'd0, 6'h07);        exp_v0[17] = 32'hF0000000; // SRAV
        imem[18] = rtype(5'd2, 5'd6, 5'd2, 5'd0, 6'h25);        exp_v0[18] = 32'hF0000003; // OR
        imem[19] = rtype(5'd2, 5'd2, 5'd2, 5'd0, 6'h21);        exp_v0[19] = 32'hE0000006; // ADDU
        imem[20] = JR_0;                                         exp_v0[20] = 32'hE0000006;
        imem[21] = NOP;                                          exp_v0[21] = 32'hE0000006;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(1);
            checks++;
            if (register_v0 !== exp_v0[i]) begin
                failures++;
                $display("FAIL alu_step%0d got=%h exp=%h", i, register_v0, exp_v0[i]);
            end
        end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL alu_halt active=%b exp=0", active); end
    endtask

    task automatic test_clk_enable;
        load_ls_prog();
        do_reset();
        step(3);
        checks++; if (data_read !== 1'b1) begin failures++; $display("FAIL ce_pre_read got=%b exp=1", data_read); end
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (instr_address !== 32'hBFC0000C || register_v0 !== 32'h0 || data_read !== 1'b0 || data_write !== 1'b0) begin
                failures++;
                $display("FAIL ce_hold%0d pc=%h v0=%h rd=%b wr=%b exp pc=bfc0000c v0=0 rd=0 wr=0",
                         i, instr_address, register_v0, data_read, data_write);
            end
        end
        clk_enable = 1'b1;
        run_to_halt("ce");
        checks++; if (register_v0 !== 32'h12345678) begin failures++; $display("FAIL ce_v0 got=%h exp=12345678", register_v0); end
    endtask

    task automatic test_reset_mid;
        load_bne_prog();
        do_reset();
        step(3);
        checks++; if (register_v0 !== 32'd1) begin failures++; $display("FAIL mid_pre_v0 got=%h exp=1", register_v0); end
        #1 reset = 1'b1;
        #1;
        checks++; if (instr_address !== RV) begin failures++; $display("FAIL mid_rst_pc got=%h exp=%h", instr_address, RV); end
        checks++; if (register_v0 !== 32'h0 || active !== 1'b1) begin failures++; $display("FAIL mid_rst_state v0=%h active=%b exp v0=0 active=1", register_v0, active); end
        @(posedge clk); #1;
        checks++; if (instr_address !== RV) begin failures++; $display("FAIL mid_rst_hold got=%h exp=%h", instr_address, RV); end
        @(negedge clk); reset = 1'b0;
        run_to_halt("mid");
        checks++; if (register_v0 !== 32'd2) begin failures++; $display("FAIL mid_v0 got=%h exp=2", register_v0); end
    endtask

    initial begin
        clear_imem();
        test_reset();
        test_branch_taken();
        test_branch_not_taken();
        test_load_store();
        test_jal();
        test_alu();
        test_clk_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
